// File: rtl/calc_pkg.sv
// Purpose: shared defaults, FSM state encoding and index width for the calc share arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package calc_pkg;

    localparam int unsigned N_REQ_DEF   = 4;
    localparam int unsigned DATA_W_DEF  = 32;
    localparam int unsigned SCALE_DEF   = 100;
    localparam int unsigned MUL_LAT_DEF = 2;

    // Width of a requester index for the default configuration.
    localparam int unsigned IDX_W_DEF = $clog2(N_REQ_DEF);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } arb_state_t;

endpackage

// File: rtl/calc_scale_pipe.sv
// Purpose: scale-by-constant datapath, out = in_a * SCALE with overflow flag.
// Latency: MUL_LAT cycles from in_valid to out_valid (MUL_LAT >= 1).
// Backpressure: none; fully pipelined, caller must consume out_valid when it appears.
//
// Ports:
//   ap_clk, ap_rst         clock, synchronous active-high reset (clears valid bits)
//   in_valid, in_a         operand strobe and unsigned operand
//   out_valid              result strobe, MUL_LAT cycles after in_valid
//   out_data, out_ovf      low DATA_W bits of the product, high-half-nonzero flag
module calc_scale_pipe
    import calc_pkg::*;
#(
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned SCALE   = SCALE_DEF,
    parameter int unsigned MUL_LAT = MUL_LAT_DEF
) (
    input  logic              ap_clk,
    input  logic              ap_rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_a,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_ovf
);

    localparam int unsigned PW = 2 * DATA_W;

    logic [PW-1:0]     product;
    logic [MUL_LAT-1:0] vld_q;
    // Each stage carries {ovf, data}; the overflow reduction is done up front
    // so later stages only move DATA_W+1 bits.
    logic [DATA_W:0]   dat_q [MUL_LAT];

    assign product = {{DATA_W{1'b0}}, in_a} * PW'(SCALE);

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= in_valid;
            for (int i = 1; i < int'(MUL_LAT); i++) begin
                vld_q[i] <= vld_q[i-1];
            end
        end
    end

    // Data stages need no reset: they are only observed under vld_q.
    always_ff @(posedge ap_clk) begin
        dat_q[0] <= {|product[PW-1:DATA_W], product[DATA_W-1:0]};
        for (int i = 1; i < int'(MUL_LAT); i++) begin
            dat_q[i] <= dat_q[i-1];
        end
    end

    assign out_valid = vld_q[MUL_LAT-1];
    assign out_data  = dat_q[MUL_LAT-1][DATA_W-1:0];
    assign out_ovf   = dat_q[MUL_LAT-1][DATA_W];

endmodule

// File: rtl/calc_share_arbiter.sv
// Purpose: round-robin share of one scale-by-constant datapath among N_REQ requesters.
// Latency: grant at T, rsp_valid at T+MUL_LAT+1, ap_done the cycle after the response handshake.
// Backpressure: one transaction in flight; response held until the owner's rsp_ready, no grants meanwhile.
//
// Ports:
//   ap_clk, ap_rst         clock, synchronous active-high reset
//   ap_start               level enable for new grants
//   ap_idle, ap_done       no transaction in flight / one-cycle completion pulse
//   req_valid, req_a       per-requester request and packed operands
//   req_ready              one-hot combinational grant in the idle cycle
//   rsp_valid, rsp_ready   one-hot registered response valid / per-requester accept
//   rsp_data, rsp_ovf      wrapped product and overflow flag
module calc_share_arbiter
    import calc_pkg::*;
#(
    parameter int unsigned N_REQ   = N_REQ_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned SCALE   = SCALE_DEF,
    parameter int unsigned MUL_LAT = MUL_LAT_DEF
) (
    input  logic                    ap_clk,
    input  logic                    ap_rst,
    input  logic                    ap_start,
    output logic                    ap_idle,
    output logic                    ap_done,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DATA_W-1:0] req_a,
    output logic [N_REQ-1:0]        req_ready,
    output logic [N_REQ-1:0]        rsp_valid,
    input  logic [N_REQ-1:0]        rsp_ready,
    output logic [DATA_W-1:0]       rsp_data,
    output logic                    rsp_ovf
);

    localparam int unsigned IDX_W = $clog2(N_REQ);

    arb_state_t         state;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   owner;
    logic [IDX_W:0]     cand;
    logic [IDX_W-1:0]   win_idx;
    logic               win_found;
    logic               grant;
    logic [DATA_W-1:0]  sel_a;
    logic               pipe_vld;
    logic [DATA_W-1:0]  pipe_dat;
    logic               pipe_ovf;

    // Cyclic search for the first valid requester at or after rr_ptr.
    // cand has one spare bit so rr_ptr + i never wraps before the modulo.
    always_comb begin
        cand      = '0;
        win_idx   = '0;
        win_found = 1'b0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            cand = {1'b0, rr_ptr} + (IDX_W+1)'(i);
            if (cand >= (IDX_W+1)'(N_REQ)) begin
                cand = cand - (IDX_W+1)'(N_REQ);
            end
            if (!win_found && req_valid[cand[IDX_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        sel_a = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (win_idx == IDX_W'(i)) begin
                sel_a = req_a[i*DATA_W +: DATA_W];
            end
        end
    end

    assign grant     = (state == S_IDLE) && ap_start && win_found;
    assign req_ready = grant ? (N_REQ'(1) << win_idx) : '0;
    assign ap_idle   = (state == S_IDLE);

    calc_scale_pipe #(
        .DATA_W  (DATA_W),
        .SCALE   (SCALE),
        .MUL_LAT (MUL_LAT)
    ) u_pipe (
        .ap_clk    (ap_clk),
        .ap_rst    (ap_rst),
        .in_valid  (grant),
        .in_a      (sel_a),
        .out_valid (pipe_vld),
        .out_data  (pipe_dat),
        .out_ovf   (pipe_ovf)
    );

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state     <= S_IDLE;
            rr_ptr    <= '0;
            owner     <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
            rsp_ovf   <= 1'b0;
            ap_done   <= 1'b0;
        end else begin
            ap_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (grant) begin
                        owner  <= win_idx;
                        rr_ptr <= (win_idx == IDX_W'(N_REQ-1)) ? '0 : win_idx + 1'b1;
                        state  <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    // Only one operand is ever in the pipe, so its valid
                    // marks the end of the MUL_LAT-cycle wait.
                    if (pipe_vld) begin
                        rsp_data  <= pipe_dat;
                        rsp_ovf   <= pipe_ovf;
                        rsp_valid <= N_REQ'(1) << owner;
                        state     <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_ready[owner]) begin
                        rsp_valid <= '0;
                        ap_done   <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
